snake_board_scanner: RTL and testbench
======================================

# snake_board_scanner

Read-only DMA stage on the display side of data memory. On each frame-start pulse it reads a fixed window of `WORDS` consecutive words from the second (VGA) port of dmem. This window is the snake board the processor writes through its `address_dmem`/`data`/`wren` port. The words are collected into a shadow buffer and published atomically as the flat `snake_data` bus consumed by the VGA renderer, so the renderer never sees a half-updated board.

## Interface
- `BASE_ADDR`, default 12'd100: dmem word address of board word 0.
- `WORDS`, default 10: number of 32-bit board words scanned per frame, range 1..64.
- `clock` in 1: sole clock, shared with processor and dmem.
- `reset` in 1: asynchronous, active-low; clears all state.
- `frame_start` in 1: single-cycle request to scan (from VGA vsync logic).
- `address_dmem_fromVGA` out 12: read address to dmem VGA port.
- `q_dmem_toVGA` in 32: dmem VGA-port read data, valid exactly 1 cycle after its address.
- `snake_data` out `WORDS*32`: published board; word i at `[32*i +: 32]`.
- `snake_valid` out 1: 1-cycle pulse when `snake_data` has just been updated.
- `busy` out 1: high while a scan is in progress.
- `overrun` out 1: 1-cycle pulse when `frame_start` arrives while busy.

## Operation
- States:
  - IDLE: wait for `frame_start`.
  - READ: issue `WORDS` addresses, one per cycle.
  - DRAIN: capture the last datum.
  - PUBLISH: copy the shadow buffer to `snake_data`.
- IDLE → READ on `frame_start`. The issue index is set to 0 and the address `BASE_ADDR` is driven in the first READ cycle.
- READ: drive `BASE_ADDR + idx` (12-bit, wraps modulo 4096), then idx++. When idx = `WORDS-1` has been issued → DRAIN.
- Capture: in every cycle after an address is issued, write `q_dmem_toVGA` into `shadow[cap_idx]`, then cap_idx++. The capture pipeline runs one cycle behind issue.
- DRAIN: capture word `WORDS-1` → PUBLISH.
- PUBLISH: `snake_data` ← shadow (all words in the same edge), assert `snake_valid` for this cycle → IDLE.
- `busy` = state ≠ IDLE.
- `frame_start` in any state ≠ IDLE is dropped: the scan in flight is unaffected and `overrun` pulses in the same cycle.
- `frame_start` in the PUBLISH cycle counts as busy: it is dropped and `overrun` pulses.
- `address_dmem_fromVGA` holds `BASE_ADDR` when not in READ.
- The block never writes dmem; write arbitration is not its concern. Processor writes that land mid-scan may tear across words, which is acceptable.

## Timing
- Reset values: `snake_data` = 0, `snake_valid` = 0, `busy` = 0, `overrun` = 0, `address_dmem_fromVGA` = `BASE_ADDR`, state = IDLE.
- Reset assertion mid-scan aborts immediately. The shadow buffer is not published and `snake_data` is cleared.
- `frame_start` sampled high at edge 0:
  - addresses at cycles 1..`WORDS`;
  - data captured at edges 2..`WORDS+1`;
  - `snake_valid` high during cycle `WORDS+2`.
- Total request-to-publish latency is `WORDS+2` cycles; 12 with defaults.
- Minimum `frame_start` spacing is `WORDS+3` cycles.
- `snake_data` changes only on the PUBLISH edge and is otherwise stable.
- All outputs are registered.

## Configuration
- `SNAKE_SCAN_CHANGE_EN` defined: at PUBLISH, shadow is compared with current `snake_data`.
  - `snake_valid` pulses only if they differ.
  - `snake_data` is updated either way.
  - Identical frames produce no pulse.
- Undefined: `snake_valid` pulses on every completed scan.

## Test plan
- Reset low at t0 with `frame_start` high → all outputs at reset values; no scan after release until a new `frame_start`.
- Dmem words 100..109 preloaded with values 0x1000+i; pulse `frame_start` → addresses 100..109 on cycles 1..10, `snake_valid` at cycle 12, `snake_data[32*i +: 32]` = 0x1000+i.
- Second `frame_start` at cycle 5 → `overrun` pulses at cycle 5, a single `snake_valid` at cycle 12, and no second scan.
- `BASE_ADDR` = 12'd4090 → addresses 4090..4095, then 0..3, and data mapped in that order.
- Reset dropped at cycle 6 of a scan → `busy` = 0, `snake_data` = 0 and no `snake_valid` in the following 20 cycles.
- With `SNAKE_SCAN_CHANGE_EN`, two scans of unchanged memory → one `snake_valid`. Then modify word 103 and rescan → second `snake_valid`, with word 3 updated.

Source files
------------

// File: rtl/snake_board_scanner.sv
// Snake board scanner: on each frame_start, reads WORDS words from the dmem VGA port and publishes them atomically on snake_data.
// Optional feature macro SNAKE_SCAN_CHANGE_EN: snake_valid pulses only when the published board actually changed.
module snake_board_scanner #(
  parameter logic [11:0] BASE_ADDR = 12'd100,
  parameter int          WORDS     = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  frame_start,
  output logic [11:0]           address_dmem_fromVGA,
  input  logic [31:0]           q_dmem_toVGA,
  output logic [WORDS*32-1:0]   snake_data,
  output logic                  snake_valid,
  output logic                  busy,
  output logic                  overrun
);

  // state   | meaning
  // IDLE    | waiting for frame_start
  // READ    | one board address issued per cycle
  // DRAIN   | last datum returns; shadow copied to snake_data on exit
  // PUBLISH | snake_valid high; frame_start here still counts as busy

  localparam int             IW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0]  LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, PUBLISH} state_t;

  state_t                state, state_d;
  logic [IW-1:0]         idx, cap_idx;
  logic                  cap_on;
  logic                  cap_do;
  logic                  publish;
  logic                  valid_d;
  logic [11:0]           addr_d;
  logic [WORDS*32-1:0]   shadow, shadow_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    addr_d  = BASE_ADDR;
    publish = 1'b0;
    case (state)
      IDLE:    if (frame_start) state_d = READ;
      READ: begin
        if (idx == LAST) state_d = DRAIN;
        else             addr_d  = BASE_ADDR + 12'(idx) + 12'd1;
      end
      DRAIN: begin
        state_d = PUBLISH;
        publish = 1'b1;
      end
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture runs one cycle behind issue, so the newest word is merged combinationally
  // and the DRAIN edge can publish the complete board without an extra cycle.
  assign cap_do = ((state == READ) && cap_on) || (state == DRAIN);

  always_comb begin
    shadow_d = shadow;
    if (cap_do) shadow_d[32*cap_idx +: 32] = q_dmem_toVGA;
  end

`ifdef SNAKE_SCAN_CHANGE_EN
  assign valid_d = publish && (shadow_d != snake_data);
`else
  assign valid_d = publish;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      address_dmem_fromVGA <= BASE_ADDR;
      snake_data           <= '0;
      snake_valid          <= 1'b0;
      busy                 <= 1'b0;
      overrun              <= 1'b0;
      shadow               <= '0;
      idx                  <= '0;
      cap_idx              <= '0;
      cap_on               <= 1'b0;
    end else begin
      address_dmem_fromVGA <= addr_d;
      busy                 <= (state_d != IDLE);
      overrun              <= frame_start && (state != IDLE);
      snake_valid          <= valid_d;
      shadow               <= shadow_d;
      if (publish) snake_data <= shadow_d;

      case (state)
        IDLE: begin
          idx     <= '0;
          cap_idx <= '0;
          cap_on  <= 1'b0;
        end
        READ: begin
          cap_on <= 1'b1;
          if (idx != LAST) idx <= idx + IW'(1);
        end
        default: ;
      endcase

      if (cap_do && (cap_idx != LAST)) cap_idx <= cap_idx + IW'(1);
    end
  end

endmodule

// File: tb/tb_snake_board_scanner.sv
// Bench for snake_board_scanner: directed table, hand sequences and random frames vs. a per-edge board snapshot model.
module tb_snake_board_scanner;

`ifdef SNAKE_SCAN_CHANGE_EN
  localparam bit CHG = 1'b1;
`else
  localparam bit CHG = 1'b0;
`endif

  localparam int NI = 3;

  logic clock = 1'b0;
  logic reset;
  logic frame_start;
  always #5 clock = ~clock;

  logic [11:0]  addr_a, addr_b, addr_c;
  logic [31:0]  q_a, q_b, q_c;
  logic [319:0] data_a, data_b;
  logic [31:0]  data_c;
  logic         valid_a, valid_b, valid_c;
  logic         busy_a, busy_b, busy_c;
  logic         ovr_a, ovr_b, ovr_c;

  logic [31:0] mem [4096];
  always @(posedge clock) begin
    q_a <= mem[addr_a];
    q_b <= mem[addr_b];
    q_c <= mem[addr_c];
  end

  snake_board_scanner #(.BASE_ADDR(12'd100), .WORDS(10)) dut_a (
    .clock(clock), .reset(reset), .frame_start(frame_start),
    .address_dmem_fromVGA(addr_a), .q_dmem_toVGA(q_a), .snake_data(data_a),
    .snake_valid(valid_a), .busy(busy_a), .overrun(ovr_a));

  snake_board_scanner #(.BASE_ADDR(12'd4090), .WORDS(10)) dut_b (
    .clock(clock), .reset(reset), .frame_start(frame_start),
    .address_dmem_fromVGA(addr_b), .q_dmem_toVGA(q_b), .snake_data(data_b),
    .snake_valid(valid_b), .busy(busy_b), .overrun(ovr_b));

  snake_board_scanner #(.BASE_ADDR(12'd7), .WORDS(1)) dut_c (
    .clock(clock), .reset(reset), .frame_start(frame_start),
    .address_dmem_fromVGA(addr_c), .q_dmem_toVGA(q_c), .snake_data(data_c),
    .snake_valid(valid_c), .busy(busy_c), .overrun(ovr_c));

  // Reference model: a scan accepted at edge s snapshots board word k at edge s+k+1,
  // publishes at edge s+W+1, and blocks new requests up to edge s+W+2.
  int          m_w    [NI] = '{10, 10, 1};
  int          m_base [NI] = '{100, 4090, 7};
  bit          m_has  [NI];
  int          m_start[NI];
  logic [31:0] m_snap [NI][64];
  logic [31:0] m_pub  [NI][64];
  bit          m_valid[NI];
  bit          m_ovr  [NI];
  int          cyc, last_edge;
  int          n_chk, n_fail;

  typedef struct {
    logic        fs;
    logic        busy;
    logic [11:0] addr;
    logic        valid;
    logic        ovr;
  } vec_t;
  vec_t tbl[14];

  function automatic logic [31:0] dut_word(input int i, input int k);
    case (i)
      0:       return data_a[32*k +: 32];
      1:       return data_b[32*k +: 32];
      default: return data_c;
    endcase
  endfunction

  function automatic logic [31:0] dut_sig(input int i, input int s);
    logic [11:0] a;
    logic b, v, o;
    case (i)
      0:       begin a = addr_a; b = busy_a; v = valid_a; o = ovr_a; end
      1:       begin a = addr_b; b = busy_b; v = valid_b; o = ovr_b; end
      default: begin a = addr_c; b = busy_c; v = valid_c; o = ovr_c; end
    endcase
    case (s)
      0:       return {20'd0, a};
      1:       return {31'd0, b};
      2:       return {31'd0, v};
      default: return {31'd0, o};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_has[i]   = 1'b0;
      m_valid[i] = 1'b0;
      m_ovr[i]   = 1'b0;
      for (int k = 0; k < 64; k++) m_pub[i][k] = '0;
    end
  endtask

  task automatic model_edge(input logic fs);
    last_edge = cyc;
    cyc++;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NI; i++) begin
      int s, w;
      bit act, diff;
      s = m_start[i];
      w = m_w[i];
      m_valid[i] = 1'b0;
      m_ovr[i]   = 1'b0;
      act = m_has[i] && (last_edge <= s + w + 2);
      if (m_has[i] && last_edge >= s + 1 && last_edge <= s + w)
        m_snap[i][last_edge-s-1] = mem[(m_base[i] + last_edge - s - 1) % 4096];
      if (m_has[i] && last_edge == s + w + 1) begin
        diff = 1'b0;
        for (int k = 0; k < w; k++) if (m_snap[i][k] != m_pub[i][k]) diff = 1'b1;
        for (int k = 0; k < w; k++) m_pub[i][k] = m_snap[i][k];
        m_valid[i] = !CHG || diff;
      end
      if (fs) begin
        if (act) m_ovr[i] = 1'b1;
        else begin
          m_has[i]   = 1'b1;
          m_start[i] = last_edge;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      int s, w, n, eb, ea;
      s  = m_start[i];
      w  = m_w[i];
      n  = last_edge;
      eb = (m_has[i] && n <= s + w + 1) ? 1 : 0;
      ea = (m_has[i] && n - s <= w - 1) ? (m_base[i] + n - s) % 4096 : m_base[i];
      chk($sformatf("addr%0d", i),  dut_sig(i, 0), ea);
      chk($sformatf("busy%0d", i),  dut_sig(i, 1), eb);
      chk($sformatf("valid%0d", i), dut_sig(i, 2), {31'd0, m_valid[i]});
      chk($sformatf("ovr%0d", i),   dut_sig(i, 3), {31'd0, m_ovr[i]});
      for (int k = 0; k < w; k++)
        chk($sformatf("data%0d_w%0d", i, k), dut_word(i, k), m_pub[i][k]);
    end
  endtask

  task automatic step(input logic fs);
    frame_start = fs;
    @(posedge clock);
    model_edge(fs);
    @(negedge clock);
    check_all();
  endtask

  task automatic scan_count(output int cnt);
    cnt = 0;
    step(1'b1);
    if (valid_a) cnt++;
    for (int j = 0; j < 13; j++) begin
      step(1'b0);
      if (valid_a) cnt++;
    end
  endtask

  initial begin
    int cnt, c1, c2, c3;
    int wa;
    int hot[20];

    tbl[0]  = '{1'b1, 1'b1, 12'd100, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 12'd101, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 12'd102, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 12'd103, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 12'd104, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 12'd105, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 12'd106, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 12'd107, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 12'd108, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 12'd109, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 12'd100, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 12'd100, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 12'd100, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 12'd100, 1'b0, 1'b0};

    for (int a = 0; a < 4096; a++) mem[a] = $urandom;
    for (int k = 0; k < 10; k++) mem[100+k] = 32'h1000 + k;
    for (int k = 0; k < 6; k++)  mem[4090+k] = 32'hB000 + k;
    for (int k = 0; k < 4; k++)  mem[k] = 32'hB006 + k;
    mem[7] = 32'h0000_C007;

    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    reset = 1'b0;
    frame_start = 1'b1;
    model_reset();

    // reset held with frame_start high, then release and stay idle
    for (int j = 0; j < 3; j++) step(1'b1);
    reset = 1'b1;
    for (int j = 0; j < 5; j++) step(1'b0);

    // directed scan with a dropped second request at edge 5
    for (int n = 0; n < 14; n++) begin
      step(tbl[n].fs);
      chk($sformatf("tbl_busy_%0d", n),  {31'd0, busy_a},  {31'd0, tbl[n].busy});
      chk($sformatf("tbl_addr_%0d", n),  {20'd0, addr_a},  {20'd0, tbl[n].addr});
      chk($sformatf("tbl_valid_%0d", n), {31'd0, valid_a}, {31'd0, tbl[n].valid});
      chk($sformatf("tbl_ovr_%0d", n),   {31'd0, ovr_a},   {31'd0, tbl[n].ovr});
    end
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("board_a_w%0d", k), data_a[32*k +: 32], 32'h1000 + k);
      chk($sformatf("wrap_b_w%0d", k),  data_b[32*k +: 32], 32'hB000 + k);
    end

    // reset dropped during cycle 6 of a scan
    step(1'b1);
    for (int j = 0; j < 5; j++) step(1'b0);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_data", data_a[31:0], 32'd0);
    chk("abort_addr", {20'd0, addr_a}, 32'd100);
    check_all();
    step(1'b0);
    step(1'b0);
    reset = 1'b1;
    cnt = 0;
    for (int j = 0; j < 20; j++) begin
      step(1'b0);
      if (valid_a) cnt++;
    end
    chk("no_valid_after_abort", cnt, 32'd0);
    chk("data_cleared_after_abort", data_a[32*9 +: 32], 32'd0);

    // repeated scans of unchanged memory, then one word modified
    scan_count(c1);
    scan_count(c2);
    mem[103] = 32'hCAFE_0003;
    scan_count(c3);
    chk("chg_scan1", c1, 32'd1);
    chk("chg_scan2", c2, CHG ? 32'd0 : 32'd1);
    chk("chg_scan3", c3, 32'd1);
    chk("chg_word3", data_a[32*3 +: 32], 32'hCAFE_0003);

    // random requests, board writes (including mid-scan) and occasional resets
    for (int k = 0; k < 10; k++) hot[k] = 100 + k;
    for (int k = 0; k < 6; k++)  hot[10+k] = 4090 + k;
    for (int k = 0; k < 3; k++)  hot[16+k] = k;
    hot[19] = 7;
    for (int j = 0; j < 800; j++) begin
      step($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 2) == 0) begin
        wa = hot[$urandom_range(0, 19)];
        mem[wa] = $urandom;
      end
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0;
        model_reset();
        step(1'b0);
        reset = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
